// File: rtl/sti_ser_fifo_if.sv
// Parallel-word load handshake and serial output bundle for sti_ser_fifo.
// The master side drives words in; the slave side is the serializer.
interface sti_ser_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    logic                    load;
    logic [DATA_W-1:0]       pi_data;
    logic [1:0]              pi_length;
    logic                    pi_fill;
    logic                    pi_msb;
    logic                    pi_low;
    logic                    pi_end;
    logic                    pi_ready;
    logic                    so_data;
    logic                    so_valid;
    logic                    so_done;
    logic [$clog2(DEPTH):0]  fifo_cnt;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  pi_ready, so_data, so_valid, so_done, fifo_cnt
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output pi_ready, so_data, so_valid, so_done, fifo_cnt
    );
endinterface

// File: rtl/sti_ser_fifo.sv
// FIFO-fed STI serializer: expands queued words into zero-padded frames of four
// lengths and shifts them out one bit per clock with no gap between frames.
module sti_ser_fifo #(
    parameter int DATA_W = 16,
    parameter int FILL_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    sti_ser_fifo_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FRAME_W = DATA_W + 2 * FILL_W;
    localparam int LEN_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        length;
        logic              fill;
        logic              msb;
        logic              low;
        logic              last;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    state_t             r_state;
    state_t             w_state_next;
    logic [FRAME_W-1:0] r_shift;
    logic [LEN_W-1:0]   r_bit_cnt;
    logic               r_msb;
    logic               r_end;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    entry_t             w_entry;
    entry_t             w_head;
    logic [FRAME_W-1:0] w_frame;
    logic [LEN_W-1:0]   w_len;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign w_ready = (r_cnt < CNT_W'(DEPTH)) && (r_state != DONE);
    assign w_push  = bus.load && w_ready;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_entry = '{data: bus.pi_data, length: bus.pi_length, fill: bus.pi_fill,
                       msb: bus.pi_msb, low: bus.pi_low, last: bus.pi_end};

    // NOTE: storage is deliberately not reset; r_cnt alone says which slots hold live words.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Frame is built right-justified, then left-justified when sent MSB-first.
    always_comb begin
        w_frame = '0;
        w_len   = LEN_W'(DATA_W);
        case (w_head.length)
            2'd0: begin
                w_frame = FRAME_W'(w_head.low ? w_head.data[DATA_W-1:DATA_W/2]
                                              : w_head.data[DATA_W/2-1:0]);
                w_len   = LEN_W'(DATA_W / 2);
            end
            2'd1: w_frame = FRAME_W'(w_head.data);
            2'd2: begin
                w_frame = w_head.fill ? FRAME_W'(w_head.data) << FILL_W : FRAME_W'(w_head.data);
                w_len   = LEN_W'(DATA_W + FILL_W);
            end
            default: begin
                w_frame = w_head.fill ? FRAME_W'(w_head.data) << (2 * FILL_W) : FRAME_W'(w_head.data);
                w_len   = LEN_W'(FRAME_W);
            end
        endcase
        if (w_head.msb) w_frame = w_frame << (LEN_W'(FRAME_W) - w_len);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cnt != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (r_bit_cnt == LEN_W'(1)) begin
                    if (r_end) begin
                        w_state_next = DONE;
                        w_flush      = 1'b1;
                    end else if (r_cnt != '0) begin
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_msb     <= 1'b0;
            r_end     <= 1'b0;
        end else if (w_pop) begin
            r_shift   <= w_frame;
            r_bit_cnt <= w_len;
            r_msb     <= w_head.msb;
            r_end     <= w_head.last;
        end else if (r_state == SEND) begin
            r_shift   <= r_msb ? r_shift << 1 : r_shift >> 1;
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
        end
    end

    assign bus.pi_ready = w_ready;
    assign bus.so_valid = (r_state == SEND);
    assign bus.so_data  = (r_state == SEND) && (r_msb ? r_shift[FRAME_W-1] : r_shift[0]);
    assign bus.so_done  = (r_state == DONE);
    assign bus.fifo_cnt = r_cnt;
endmodule

// File: tb/tb_sti_ser_fifo.sv
// Scoreboard bench for sti_ser_fifo: expected frame bits are queued when a word is
// loaded and compared bit by bit as the serial output produces them.
module tb_sti_ser_fifo;
    localparam int DATA_W = 16;
    localparam int FILL_W = 8;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   sb_q[$];

    sti_ser_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sti_ser_fifo #(.DATA_W(DATA_W), .FILL_W(FILL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected transmit order of one frame, derived from the frame-format table.
    function automatic void push_frame(input logic [15:0] data, input logic [1:0] mode,
                                       input logic fill, input logic msb, input logic low);
        logic [31:0] content;
        int          len;
        case (mode)
            2'd0: begin len = 8;  content = low ? {24'd0, data[15:8]} : {24'd0, data[7:0]}; end
            2'd1: begin len = 16; content = {16'd0, data}; end
            2'd2: begin len = 24; content = fill ? {8'd0, data, 8'd0} : {16'd0, data}; end
            default: begin len = 32; content = fill ? {data, 16'd0} : {16'd0, data}; end
        endcase
        for (int i = 0; i < len; i++) sb_q.push_back(content[msb ? len - 1 - i : i]);
    endfunction

    // Called at a falling edge; presents one word for the next rising edge.
    task automatic load_word(input logic [15:0] data, input logic [1:0] mode, input logic fill,
                             input logic msb, input logic low, input logic last,
                             input logic exp_ready, input logic sent, input string tag);
        bus.load      = 1'b1;
        bus.pi_data   = data;
        bus.pi_length = mode;
        bus.pi_fill   = fill;
        bus.pi_msb    = msb;
        bus.pi_low    = low;
        bus.pi_end    = last;
        check({tag, "_ready"}, 32'(bus.pi_ready), 32'(exp_ready));
        if (sent) push_frame(data, mode, fill, msb, low);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Counts consecutive valid cycles starting at the current falling edge.
    task automatic expect_run(input int n, input string tag);
        int run = 0;
        while (bus.so_valid === 1'b1 && run < 200) begin
            run++;
            @(negedge clk);
        end
        check(tag, run, n);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.so_valid === 1'b1) begin
                check("sb_has_bit", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) check("so_data", 32'(bus.so_data), 32'(sb_q.pop_front()));
            end else begin
                check("so_data_idle", 32'(bus.so_data), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.load      = 1'b0;
        bus.pi_data   = '0;
        bus.pi_length = 2'd0;
        bus.pi_fill   = 1'b0;
        bus.pi_msb    = 1'b0;
        bus.pi_low    = 1'b0;
        bus.pi_end    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.so_valid), 32'd0);
        check("rst_data",  32'(bus.so_data),  32'd0);
        check("rst_done",  32'(bus.so_done),  32'd0);
        check("rst_ready", 32'(bus.pi_ready), 32'd1);
        check("rst_cnt",   32'(bus.fifo_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Mode 1, MSB-first: first bit one edge after acceptance, 16 bits.
        load_word(16'hA5C3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t1");
        check("t1_lat_idle", 32'(bus.so_valid), 32'd0);
        check("t1_cnt", 32'(bus.fifo_cnt), 32'd1);
        @(negedge clk);
        expect_run(16, "t1_len");
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Mode 0, upper half, LSB-first.
        load_word(16'h8001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "t2");
        @(negedge clk);
        expect_run(8, "t2_len");
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Mode 3 with both pad placements, back to back.
        load_word(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t3a");
        load_word(16'hFFFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t3b");
        expect_run(64, "t3_len");
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Overfill the FIFO while the first frame is sending; last two are refused.
        load_word(16'h1357, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t4_first");
        @(negedge clk);
        begin
            logic [15:0] words [6] = '{16'h2468, 16'h9ABC, 16'h0F0F, 16'hF00D, 16'hDEAD, 16'hBEEF};
            for (int i = 0; i < 6; i++)
                load_word(words[i], 2'd1, 1'b0, 1'(i % 2), 1'b0, 1'b0,
                          1'(i < 4), 1'(i < 4), $sformatf("t4_w%0d", i));
        end
        check("t4_cnt_full", 32'(bus.fifo_cnt), 32'd4);
        check("t4_ready_full", 32'(bus.pi_ready), 32'd0);
        expect_run(74, "t4_len");
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // End marker on the second word; the third word is queued but discarded.
        load_word(16'h00F0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t5a");
        load_word(16'h5AA5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "t5b");
        load_word(16'h7777, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5c");
        expect_run(23, "t5_len");
        check("t5_done", 32'(bus.so_done), 32'd1);
        check("t5_ready", 32'(bus.pi_ready), 32'd0);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        load_word(16'h1111, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5_in_done");
        repeat (20) @(negedge clk);
        check("t5_done_sticky", 32'(bus.so_done), 32'd1);
        check("t5_valid_low", 32'(bus.so_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("t5_rst_done",  32'(bus.so_done),  32'd0);
        check("t5_rst_ready", 32'(bus.pi_ready), 32'd1);
        check("t5_rst_cnt",   32'(bus.fifo_cnt), 32'd0);
        check("t5_rst_valid", 32'(bus.so_valid), 32'd0);
        check("t5_rst_data",  32'(bus.so_data),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during the 5th bit of a mode 2 frame, then a clean frame.
        load_word(16'h1234, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t6a");
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_abort_valid", 32'(bus.so_valid), 32'd0);
        check("t6_abort_cnt", 32'(bus.fifo_cnt), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        load_word(16'hC3A5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t6b");
        check("t6b_lat_idle", 32'(bus.so_valid), 32'd0);
        @(negedge clk);
        check("t6b_lat_valid", 32'(bus.so_valid), 32'd1);
        expect_run(24, "t6b_len");
        check("t6b_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
